// File: rtl/bp_port_scheduler_if.sv
// Handshake and table-port bundle between fetch, EX resolve, the scheduler and the predictor RAM.
// Entry layout on tbl_wdata/tbl_rdata: {valid, tag, ctr[1:0], target[31:2]}.
interface bp_port_scheduler_if #(
  parameter int INDEX_BITS = 6
);
  logic                   lk_valid;
  logic [31:0]            lk_pc;
  logic                   lk_ready;
  logic                   lk_rvalid;
  logic                   lk_hit;
  logic                   lk_taken;
  logic [31:0]            lk_target;
  logic                   flush;
  logic                   upd_valid;
  logic [31:0]            upd_pc;
  logic                   upd_taken;
  logic [31:0]            upd_target;
  logic                   upd_ready;
  logic                   tbl_en;
  logic                   tbl_we;
  logic [INDEX_BITS-1:0]  tbl_addr;
  logic [62-INDEX_BITS:0] tbl_wdata;
  logic [62-INDEX_BITS:0] tbl_rdata;
  logic                   init_done;

  modport slave (
    input  lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, upd_target, tbl_rdata,
    output lk_ready, lk_rvalid, lk_hit, lk_taken, lk_target, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );

  modport master (
    output lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, upd_target, tbl_rdata,
    input  lk_ready, lk_rvalid, lk_hit, lk_taken, lk_target, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );
endinterface

// File: rtl/bp_port_scheduler.sv
// Arbitrates the predictor's single table port between fetch lookups and queued resolution updates.
// Lookups answer one cycle after acceptance; updates cost a read plus a write cycle and are buffered in a small FIFO.
module bp_port_scheduler #(
  parameter int INDEX_BITS   = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bp_port_scheduler_if.slave   io
);

  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_URD} state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [29:0]      target;
  } entry_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        taken;
    logic [29:0] target;
  } upd_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic                  init_done_q, init_done_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic                  rvalid_q, rvalid_d;
  logic [TAG_W-1:0]      lk_tag_q, lk_tag_d;
  upd_t                  fifo_mem_q [FIFO_DEPTH];

  logic                  fifo_full, fifo_nempty, force_upd, push, pop;
  logic                  tbl_en, tbl_we, lk_ready, lk_rvalid, lk_hit;
  logic [INDEX_BITS-1:0] tbl_addr;
  entry_t                wdata, rd_entry;
  upd_t                  head;
  logic [INDEX_BITS-1:0] head_idx;
  logic [TAG_W-1:0]      head_tag;
  logic                  lint_unused;

  assign fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nempty = (cnt_q != '0);
  assign head        = fifo_mem_q[rd_ptr_q];
  assign head_idx    = head.pc[INDEX_BITS-1:0];
  assign head_tag    = head.pc[29:INDEX_BITS];
  assign rd_entry    = entry_t'(io.tbl_rdata);
  assign force_upd   = fifo_nempty &&
                       (fifo_full || (starve_q >= SC_W'(STARVE_LIMIT)) || !io.lk_valid);

  assign io.upd_ready = (state_q != S_INIT) && !fifo_full;
  assign push         = io.upd_valid && io.upd_ready;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    rvalid_d    = 1'b0;
    lk_tag_d    = lk_tag_q;
    pop         = 1'b0;
    tbl_en      = 1'b0;
    tbl_we      = 1'b0;
    tbl_addr    = '0;
    wdata       = '0;
    lk_ready    = 1'b0;
    case (state_q)
      S_INIT: begin
        tbl_en   = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = sweep_q;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (force_upd) begin
          tbl_en   = 1'b1;
          tbl_addr = head_idx;
          state_d  = S_URD;
          starve_d = '0;
        end else begin
          lk_ready = 1'b1;
          if (io.lk_valid) begin
            tbl_en   = 1'b1;
            tbl_addr = io.lk_pc[INDEX_BITS+1:2];
            lk_tag_d = io.lk_pc[31:INDEX_BITS+2];
            rvalid_d = 1'b1;
            if (fifo_nempty && (starve_q < SC_W'(STARVE_LIMIT)))
              starve_d = starve_q + 1'b1;
          end
        end
      end
      S_URD: begin
        pop      = 1'b1;
        state_d  = S_IDLE;
        tbl_addr = head_idx;
        wdata    = rd_entry;
        if (rd_entry.valid && (rd_entry.tag == head_tag)) begin
          tbl_en = 1'b1;
          tbl_we = 1'b1;
          if (head.taken) begin
            wdata.ctr    = (rd_entry.ctr == 2'd3) ? 2'd3 : rd_entry.ctr + 2'd1;
            wdata.target = head.target;
          end else begin
            wdata.ctr    = (rd_entry.ctr == 2'd0) ? 2'd0 : rd_entry.ctr - 2'd1;
          end
        end else if (head.taken) begin
          tbl_en = 1'b1;
          tbl_we = 1'b1;
          wdata  = '{valid: 1'b1, tag: head_tag, ctr: 2'b10, target: head.target};
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      rvalid_q    <= 1'b0;
      lk_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      rvalid_q    <= rvalid_d;
      lk_tag_q    <= lk_tag_d;
    end
  end

  // FIFO payload needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem_q[wr_ptr_q] <= '{pc: io.upd_pc[31:2], taken: io.upd_taken,
                                target: io.upd_target[31:2]};
  end

  // The port is held quiet while reset is asserted, even though state already reads S_INIT.
  assign io.tbl_en    = tbl_en && !reset;
  assign io.tbl_we    = tbl_we && !reset;
  assign io.tbl_addr  = tbl_addr;
  assign io.tbl_wdata = wdata;
  assign io.lk_ready  = lk_ready;
  assign io.init_done = init_done_q;

  assign lk_rvalid    = rvalid_q && !io.flush;
  assign lk_hit       = lk_rvalid && rd_entry.valid && (rd_entry.tag == lk_tag_q);
  assign io.lk_rvalid = lk_rvalid;
  assign io.lk_hit    = lk_hit;
  assign io.lk_taken  = lk_hit && rd_entry.ctr[1];
  assign io.lk_target = lk_rvalid ? {rd_entry.target, 2'b00} : 32'd0;

  assign lint_unused = ^{io.lk_pc[1:0], io.upd_pc[1:0], io.upd_target[1:0]};

endmodule

// File: doc/bp_port_scheduler.md
Name: bp_port_scheduler

Overview:
- Controller for the branch predictor's single-port prediction table (BTB plus 2-bit counters).
- Shares the table port between fetch-stage lookups (PCnow) and execute-stage resolution updates.
- Buffers updates in a small FIFO, performs the read-modify-write of each entry, and clears the table after reset.
- Sits between the fetch PC logic, the EX branch-resolve logic and the predictor RAM.

Parameters:
- INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries.
- FIFO_DEPTH, 4, update FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, accepted lookups with a pending update before that update is forced.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lk_valid  in  1  fetch lookup request.
- lk_pc  in  32  PC to predict.
- lk_ready  out  1  lookup accepted this cycle when lk_valid && lk_ready.
- lk_rvalid  out  1  prediction valid; one cycle after acceptance.
- lk_hit  out  1  entry valid and tag match.
- lk_taken  out  1  predicted taken; equals counter[1] && hit.
- lk_target  out  32  predicted target, {target30, 2'b00}.
- flush  in  1  kills the in-flight lookup response.
- upd_valid  in  1  resolved branch push.
- upd_pc  in  32  branch PC.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target.
- upd_ready  out  1  FIFO not full.
- tbl_en  out  1  table port enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  INDEX_BITS  table index.
- tbl_wdata  out  63-INDEX_BITS  entry {valid, tag, ctr[1:0], target[31:2]}.
- tbl_rdata  in  63-INDEX_BITS  read data; valid the cycle after a read.
- init_done  out  1  table clear complete.

Behaviour:
- Field mapping: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; target field = target[31:2].
- Reset values: all outputs 0; FIFO empty; starve count 0; state S_INIT with sweep index 0. Asserting reset at any point, including mid-sweep or mid-update, discards all state and restarts the sweep.
- S_INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_wdata=0, tbl_addr=sweep index.
  - The sweep index increments; after index 2^INDEX_BITS-1, go to S_IDLE and set init_done=1 (sticky until reset).
  - lk_ready=0 and upd_ready=0 throughout.
- Grant rule in S_IDLE: define force = FIFO nonempty && (FIFO full || starve_cnt >= STARVE_LIMIT || !lk_valid).
  - lk_ready = (state==S_IDLE) && !force.
- Lookup accept, cycle t: tbl_en=1, tbl_we=0, tbl_addr=index(lk_pc); the lookup tag is registered.
  - Cycle t+1: lk_rvalid=1 unless flush was high in cycle t+1.
  - lk_hit, lk_taken, lk_target are decoded combinationally from tbl_rdata. They are 0 when lk_rvalid=0.
  - Back-to-back lookups give one response per cycle.
- Update grant, cycle t (S_IDLE && force): tbl_en=1, tbl_we=0, tbl_addr=index(head); go to S_URD; starve_cnt cleared.
- S_URD, cycle t+1: compute the new entry from tbl_rdata and the FIFO head, pop the head, return to S_IDLE. lk_ready=0.
  - Hit (valid && tag equal):
    - tbl_we=1.
    - ctr: +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
    - target replaced only if taken.
  - Miss and taken: tbl_we=1, entry = {1, tag, 2'b10, target}.
  - Miss and not taken: tbl_en=0 (no write); the head is still popped.
- Update cost: exactly 2 port cycles, during which no lookup is accepted.
- Read-after-write: a lookup accepted the cycle after S_URD sees the written entry.
- starve_cnt increments, saturating at STARVE_LIMIT, on each accepted lookup while the FIFO is nonempty.
- FIFO:
  - upd_ready = !full, computed from the registered count.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- flush affects only lk_rvalid; queued updates are never dropped.

Test Plan:
- Reset: release reset, hold lk_valid=1 -> exactly 64 cycles with tbl_we=1, tbl_wdata=0, addr 0..63; init_done rises; first lookup accepted on cycle 65; response lk_hit=0.
- Allocate then predict: push upd_pc=0x0040_0010, taken=1, target=0x0040_0100, lk_valid=0 -> read then write at addr 4 with ctr=2'b10. Next lookup of 0x0040_0010 -> hit=1, taken=1, target=0x0040_0100.
- Saturation: 3 taken updates to one PC -> ctr=3; then 4 not-taken -> ctr 2,1,0,0; lookup -> hit=1, taken=0. A not-taken update to an unallocated PC -> no write cycle, FIFO count decrements.
- Starvation: lk_valid held at 1, one update queued -> 8 lookups accepted, then lk_ready=0 for 2 cycles while the update executes, then lookups resume.
- FIFO full: push 5 updates in 5 consecutive cycles with lk_valid=1 -> upd_ready=0 after the 4th; 5th ignored; the update is forced the cycle the FIFO becomes full.
- Flush / reset mid-op: flush in the response cycle -> lk_rvalid=0. Reset asserted in S_URD -> no write issued, FIFO empty, sweep restarts from 0.
